// File: rtl/lib_allocator_pkg.sv
// Shared types and helpers for the iSLIP separable allocator.
package lib_allocator_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } alloc_state_t;

  // Width needed to index n items; at least one bit so n=1 still yields a legal vector.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lib_ppe_rr_ptr.sv
// Programmable priority encoder: one-hot grant to the first request at or after the pointer,
// wrapping modulo W. Purely combinational.
module lib_ppe_rr_ptr #(
  parameter int W  = 4,
  parameter int PW = lib_allocator_pkg::ptr_w(W)
) (
  input  logic [0:W-1]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [0:W-1]  o_gnt
);

  int   idx;
  logic found;

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block infers a latch.
    o_gnt = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < W; k++) begin
      idx = (int'(i_ptr) + k) % W;
      if (!found && i_req[idx]) begin
        o_gnt[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lib_allocator_islip.sv
// N x M iSLIP allocator: up to ITER grant/accept iterations per allocation, one per clock,
// with round-robin pointers advanced only by first-iteration accepts.
module lib_allocator_islip
  import lib_allocator_pkg::*;
#(
  parameter int N    = 4,
  parameter int M    = 4,
  parameter int ITER = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_start,
  input  logic [0:N-1][0:M-1]  i_request,
  output logic                 o_busy,
  output logic                 o_valid,
  output logic [0:N-1][0:M-1]  o_grant
);

  localparam int GW = ptr_w(N);
  localparam int AW = ptr_w(M);
  localparam int CW = ptr_w(ITER);

  alloc_state_t        state_q, state_d;
  logic [0:N-1][0:M-1] req_q, req_d;
  logic [0:N-1][0:M-1] match_q, match_d;
  logic [0:N-1][0:M-1] grant_q, grant_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [GW-1:0]       g_ptr_q [M];
  logic [GW-1:0]       g_ptr_d [M];
  logic [AW-1:0]       a_ptr_q [N];
  logic [AW-1:0]       a_ptr_d [N];

  logic [0:N-1]        in_matched;
  logic [0:M-1]        out_matched;
  logic [0:N-1]        out_req [M];
  logic [0:N-1]        out_gnt [M];
  logic [0:M-1]        in_gnt  [N];
  logic [0:M-1]        in_acc  [N];

  logic [0:N-1][0:M-1] acc_m, merged;
  logic [0:N-1]        in_done;
  logic [0:M-1]        out_done;
  logic                any_elig;

  // Grant stage input: column j of the captured requests restricted to still-free pairs.
  always_comb begin
    in_matched  = '0;
    out_matched = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        in_matched[i]  = in_matched[i]  | match_q[i][j];
        out_matched[j] = out_matched[j] | match_q[i][j];
      end
    end
    for (int j = 0; j < M; j++) begin
      out_req[j] = '0;
      for (int i = 0; i < N; i++)
        out_req[j][i] = req_q[i][j] & ~in_matched[i] & ~out_matched[j];
    end
  end

  for (genvar gj = 0; gj < M; gj++) begin : g_grant
    lib_ppe_rr_ptr #(.W(N), .PW(GW)) u_ppe (
      .i_req (out_req[gj]),
      .i_ptr (g_ptr_q[gj]),
      .o_gnt (out_gnt[gj])
    );
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_gnt[i] = '0;
      for (int j = 0; j < M; j++)
        in_gnt[i][j] = out_gnt[j][i];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_accept
    lib_ppe_rr_ptr #(.W(M), .PW(AW)) u_ppe (
      .i_req (in_gnt[gi]),
      .i_ptr (a_ptr_q[gi]),
      .o_gnt (in_acc[gi])
    );
  end

  // Matching after this iteration and whether any request could still be served.
  always_comb begin
    acc_m    = '0;
    in_done  = '0;
    out_done = '0;
    any_elig = 1'b0;
    for (int i = 0; i < N; i++)
      acc_m[i] = in_acc[i];
    merged = match_q | acc_m;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < M; j++) begin
        in_done[i]  = in_done[i]  | merged[i][j];
        out_done[j] = out_done[j] | merged[i][j];
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++)
        if (req_q[i][j] && !in_done[i] && !out_done[j]) any_elig = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    match_d = match_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    g_ptr_d = g_ptr_q;
    a_ptr_d = a_ptr_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          req_d   = i_request;
          match_d = '0;
          cnt_d   = '0;
          state_d = lib_allocator_pkg::ITER;
        end
      end
      lib_allocator_pkg::ITER: begin
        match_d = merged;
        if (cnt_q == '0) begin
          for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
              if (acc_m[i][j]) begin
                g_ptr_d[j] = GW'((i + 1) % N);
                a_ptr_d[i] = AW'((j + 1) % M);
              end
            end
          end
        end
        if ((int'(cnt_q) == ITER - 1) || (acc_m == '0) || !any_elig) begin
          grant_d = merged;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      match_q <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      // NOTE: the pointer arrays are small flop banks, not RAM, so they take the async reset too.
      for (int j = 0; j < M; j++) g_ptr_q[j] <= '0;
      for (int i = 0; i < N; i++) a_ptr_q[i] <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      req_q   <= req_d;
      match_q <= match_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      g_ptr_q <= g_ptr_d;
      a_ptr_q <= a_ptr_d;
    end
  end

  always_comb begin
    o_busy  = (state_q != IDLE);
    o_valid = (state_q == DONE);
    o_grant = grant_q;
  end

  logic         grant_ok;
  logic [0:N-1] col;

  always_comb begin
    grant_ok = 1'b1;
    col      = '0;
    for (int i = 0; i < N; i++)
      if ($countones(grant_q[i]) > 1) grant_ok = 1'b0;
    for (int j = 0; j < M; j++) begin
      for (int i = 0; i < N; i++) col[i] = grant_q[i][j];
      if ($countones(col) > 1) grant_ok = 1'b0;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n) grant_ok);

endmodule
